// File: rtl/rvvicsrpkg.sv
// Shared types and the fixed CSR bit-to-address map for the RVVI CSR write sequencer.
// Both enable-vector widths use the same map; the 54-entry map extends the 36-entry one.
package rvvicsrpkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int CSRS_SMALL = 36;
  localparam int CSRS_LARGE = 54;

  localparam logic [11:0] CSR_ADDR_36 [36] = '{
    12'h300, 12'h310, 12'h305, 12'h341, 12'h306, 12'h320, 12'h302, 12'h303,
    12'h344, 12'h304, 12'h301, 12'h30A, 12'hF14, 12'h340, 12'h342, 12'h343,
    12'hF11, 12'hF12, 12'hF13, 12'hF15, 12'h34A, 12'h100, 12'h104, 12'h105,
    12'h141, 12'h106, 12'h10A, 12'h180, 12'h140, 12'h143, 12'h142, 12'h144,
    12'h14D, 12'h001, 12'h002, 12'h003
  };

  localparam logic [11:0] CSR_ADDR_54 [54] = '{
    12'h300, 12'h310, 12'h305, 12'h341, 12'h306, 12'h320, 12'h302, 12'h303,
    12'h344, 12'h304, 12'h301, 12'h30A, 12'hF14, 12'h340, 12'h342, 12'h343,
    12'hF11, 12'hF12, 12'hF13, 12'hF15, 12'h34A, 12'h100, 12'h104, 12'h105,
    12'h141, 12'h106, 12'h10A, 12'h180, 12'h140, 12'h143, 12'h142, 12'h144,
    12'h14D, 12'h001, 12'h002, 12'h003,
    12'h3B0, 12'h3B1, 12'h3B2, 12'h3B3, 12'h3B4, 12'h3B5, 12'h3B6, 12'h3B7,
    12'h3B8, 12'h3B9, 12'h3BA, 12'h3BB, 12'h3BC, 12'h3BD, 12'h3BE, 12'h3BF,
    12'h3A0, 12'h3A2
  };

  function automatic logic total_csrs_ok(input int total);
    return (total == CSRS_SMALL) || (total == CSRS_LARGE);
  endfunction

  function automatic logic [11:0] csr_addr(input int total, input logic [5:0] idx);
    if (total == CSRS_SMALL)
      return (idx < 6'd36) ? CSR_ADDR_36[idx] : 12'h000;
    return (idx < 6'd54) ? CSR_ADDR_54[idx] : 12'h000;
  endfunction

endpackage

// File: rtl/csrwritesequencer_lsbpick.sv
// Lowest-set-bit picker: one-hot of the lowest set bit, its index, the vector with it cleared.
// Purely combinational, no handshake.
module lsbpick #(
  parameter int N  = 36,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  rest,
  output logic          zero
);

  assign onehot = vec & (~vec + {{(N-1){1'b0}}, 1'b1});
  assign rest   = vec & ~onehot;
  assign zero   = (vec == '0);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[IW-1:0];
    end
  end

endmodule

// File: rtl/csrwritesequencer.sv
// Serializes a multi-hot CSR write vector into one (addr, value) record per cycle; first record
// one cycle after accept; output held stable under OutReady low, input refused until the last record drains.
module csrwritesequencer
  import rvvicsrpkg::*;
#(
  parameter int TOTAL_CSRS = 36,
  parameter int XLEN       = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             InstrValid,
  input  logic [TOTAL_CSRS-1:0]            CSRWen,
  input  logic [TOTAL_CSRS-1:0][XLEN-1:0]  CSRValue,
  output logic                             InReady,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic [11:0]                      OutAddr,
  output logic [XLEN-1:0]                  OutData,
  output logic                             OutLast,
  output logic                             Overrun
);

  localparam int IW = $clog2(TOTAL_CSRS);

  if (!total_csrs_ok(TOTAL_CSRS)) begin : g_bad_total
    $error("csrwritesequencer: TOTAL_CSRS must be 36 or 54");
  end

  state_t state, state_nx;
  logic [TOTAL_CSRS-1:0]           pending, pending_nx;
  logic [TOTAL_CSRS-1:0][XLEN-1:0] snap;
  logic [11:0]                     addr_nx;
  logic [XLEN-1:0]                 data_nx;
  logic                            last_nx;

  logic [TOTAL_CSRS-1:0] wen_oh, wen_rest, pend_oh, pend_rest;
  logic [IW-1:0]         wen_idx, pend_idx;
  logic                  wen_zero, pend_zero;
  logic [XLEN-1:0]       wen_dat, pend_dat;
  logic                  accept, advance, take_in;

  lsbpick #(.N(TOTAL_CSRS), .IW(IW)) u_wen_pick (
    .vec(CSRWen), .onehot(wen_oh), .idx(wen_idx), .rest(wen_rest), .zero(wen_zero)
  );

  lsbpick #(.N(TOTAL_CSRS), .IW(IW)) u_pend_pick (
    .vec(pending), .onehot(pend_oh), .idx(pend_idx), .rest(pend_rest), .zero(pend_zero)
  );

  assign OutValid = (state == EMIT);
  assign advance  = OutValid & OutReady;
  assign InReady  = (state == IDLE) | (advance & OutLast);
  assign accept   = InstrValid & InReady;
  assign take_in  = accept & ~wen_zero;

  // One-hot muxes: the first record reads live CSRValue, later ones read the snapshot.
  always_comb begin
    wen_dat  = '0;
    pend_dat = '0;
    for (int i = 0; i < TOTAL_CSRS; i++) begin
      wen_dat  = wen_dat  | (CSRValue[i] & {XLEN{wen_oh[i]}});
      pend_dat = pend_dat | (snap[i]     & {XLEN{pend_oh[i]}});
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    addr_nx    = OutAddr;
    data_nx    = OutData;
    last_nx    = OutLast;
    if (take_in) begin
      state_nx   = EMIT;
      pending_nx = wen_rest;
      addr_nx    = csr_addr(TOTAL_CSRS, 6'(wen_idx));
      data_nx    = wen_dat;
      last_nx    = (wen_rest == '0);
    end else if (advance) begin
      if (!pend_zero) begin
        pending_nx = pend_rest;
        addr_nx    = csr_addr(TOTAL_CSRS, 6'(pend_idx));
        data_nx    = pend_dat;
        last_nx    = (pend_rest == '0);
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      OutAddr <= '0;
      OutData <= '0;
      OutLast <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      OutAddr <= addr_nx;
      OutData <= data_nx;
      OutLast <= last_nx;
      if (InstrValid && !InReady) Overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (take_in) snap <= CSRValue;
  end

endmodule

// File: doc/csrwritesequencer.md
# csrwritesequencer

Serializes the multi-hot per-instruction CSR write-enable vector from the RVVI trace path into a stream of single (CSR address, value) records, one per cycle, over a valid/ready handshake. It sits between the retired-instruction capture stage and the RVVI packetizer. An instruction that writes several CSRs (e.g. a trap updating mstatus, mepc, mcause and mtval) produces one record per written CSR.

## Interface
- TOTAL_CSRS, 36: width of the CSR enable vector; 36 and 54 are the only legal values, and any other value is an elaboration error.
- XLEN, 64: CSR value width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- InstrValid  in  1  retired-instruction CSR record present.
- CSRWen  in  TOTAL_CSRS  per-CSR write enables, multi-hot.
- CSRValue  in  TOTAL_CSRS×XLEN  post-write value of every tracked CSR.
- InReady  out  1  a record is accepted this cycle if InstrValid is also high.
- OutValid  out  1  output record valid.
- OutReady  in  1  consumer accepts the output record.
- OutAddr  out  12  CSR address.
- OutData  out  XLEN  CSR value.
- OutLast  out  1  final record for this instruction.
- Overrun  out  1  sticky flag: InstrValid was asserted while InReady was low.

## Operation
- Bit-to-address map. The map is fixed and is the same for 36 and 54.
  - Bits 0–15: 300, 310, 305, 341, 306, 320, 302, 303, 344, 304, 301, 30A, F14, 340, 342, 343.
  - Bits 16–35: F11, F12, F13, F15, 34A, 100, 104, 105, 141, 106, 10A, 180, 140, 143, 142, 144, 14D, 001, 002, 003.
  - Bits 36–51: 3B0–3BF.
  - Bits 52–53: 3A0, 3A2.
- States:
  - IDLE: no records pending.
  - EMIT: OutValid is high.
- Accept: occurs when InstrValid and InReady are both high.
  - If CSRWen is 0: nothing is emitted and the state stays IDLE.
  - Otherwise:
    - Snapshot CSRValue into the value registers.
    - Load the output registers from the lowest set bit of CSRWen.
    - Set Pending = CSRWen with the lowest set bit cleared.
    - Go to EMIT.
- Order: records are emitted in ascending bit index, not ascending address.
- Advance (OutValid and OutReady both high):
  - If Pending ≠ 0: load the lowest set bit of Pending into the output registers and clear that bit.
  - If Pending = 0: OutValid falls, unless a new accept happens in the same cycle.
- OutLast = 1 exactly when the emitted record is the final one, i.e. Pending was 0 after removal at load time.
- InReady = (state == IDLE) | (OutValid & OutReady & OutLast). This is combinational and allows back-to-back instructions with no bubble.
- While OutValid is high and OutReady is low, OutAddr, OutData and OutLast hold stable.
- Overrun:
  - Set when InstrValid is high and InReady is low.
  - That input record is dropped and the in-flight record is unaffected.
  - Cleared only by reset.

## Timing
- Latency: a record accepted at edge N has its first output visible after edge N (OutValid high in cycle N+1).
- Throughput: one record per cycle while OutReady stays high.
- A k-bit CSRWen occupies exactly k cycles of OutValid at full throughput.
- Reset values:
  - OutValid = 0, OutLast = 0, OutAddr = 0, OutData = 0.
  - Overrun = 0, Pending = 0, state = IDLE.
  - InReady = 1 in the first cycle after reset.
- Reset mid-EMIT: pending records are discarded and no partial record is emitted afterwards.
- Simultaneous final-record accept and new InstrValid: the new record loads at the same edge, and OutValid stays high continuously.
- OutData is taken from the snapshot, never from live CSRValue after the accept.

## Structure
- Shared package `rvvicsrpkg`:
  - CSR address constant arrays for 36 and 54 entries.
  - The state enum.
  - Supported TOTAL_CSRS values.
- Sub-module `lsbpick`, parameterized by width N:
  - Input: a vector.
  - Outputs: the one-hot lowest set bit, its binary index, the remainder, and a zero flag.
  - Used on both CSRWen and Pending.

## Test plan
- Single write: CSRWen = 0x1, CSRValue[0] = 0x8000_0000_0000_1888, OutReady = 1 → one record, OutAddr = 0x300, OutData matches, OutLast = 1, OutValid high for 1 cycle.
- Trap set: CSRWen = 0x600C (bits 2, 3, 13, 14) → records 305, 341, 340, 342 on consecutive cycles, with OutLast only on 342.
- Backpressure: CSRWen = 0x3 with OutReady low for 5 cycles → OutAddr holds 0x300 and data is stable; after release, 0x310 follows next cycle; InReady stays 0 throughout.
- Back-to-back: second InstrValid (CSRWen = bit 35) in the OutLast-accept cycle of the first → no OutValid gap, OutAddr = 0x003, Overrun = 0. Zero-enable record (CSRWen = 0) → no output. InstrValid while busy → Overrun = 1 and the record is dropped.
- TOTAL_CSRS = 54, CSRWen = bits 36, 51, 53 → 3B0, 3BF, 3A2. CSRValue is changed after the accept, and OutData must still show the snapshot values.
- Reset asserted mid-EMIT with 3 records pending → next cycle OutValid = 0 and InReady = 1; no stale records appear after reset.
